// File: rtl/rf80386_pkg.sv
// Shared types for the rf80386 segment-descriptor path: selectors, descriptors,
// fetch-engine states and fault codes.
package rf80386_pkg;

  typedef struct packed {
    logic [12:0] ndx;
    logic        ti;
    logic [1:0]  rpl;
  } selector_t;

  typedef struct packed {
    logic [7:0]  base_hi;
    logic [7:0]  flags_limit_hi;
    logic [7:0]  access;
    logic [7:0]  base_mid;
    logic [15:0] base_lo;
    logic [15:0] limit_lo;
  } desc386_t;

  typedef enum logic [1:0] {
    FLT_NONE,
    FLT_NULLSEL,
    FLT_LIMIT,
    FLT_BUSERR
  } e_desc_fault;

  typedef enum logic [2:0] {
    DF_IDLE,
    DF_CHECK,
    DF_FETCH,
    DF_FETCH_ACK,
    DF_DONE
  } e_descfetch_state;

  // Cache tag is {ti, ndx}; ti sits in the MSB so LDT entries are easy to pick out.
  localparam int DESC_TAG_W = 14;

  function automatic int desc_beats(input int dbw);
    return 64 / dbw;
  endfunction

endpackage

// File: rtl/rf80386_desc_fetch_if.sv
// Wishbone-style read master bus used by the descriptor fetch engine.
interface rf80386_desc_fetch_if #(
  parameter int DBW = 32,
  parameter int AW  = 32
);
  logic             cyc_o;
  logic             stb_o;
  logic             we_o;
  logic [DBW/8-1:0] sel_o;
  logic [AW-1:0]    adr_o;
  logic             ack_i;
  logic             err_i;
  logic [DBW-1:0]   dat_i;

  modport master (
    output cyc_o, stb_o, we_o, sel_o, adr_o,
    input  ack_i, err_i, dat_i
  );

  modport slave (
    input  cyc_o, stb_o, we_o, sel_o, adr_o,
    output ack_i, err_i, dat_i
  );
endinterface

// File: rtl/rf80386_desc_cache.sv
// Small fully-associative descriptor cache: tag match, round-robin fill and
// whole/LDT-only invalidation.
module rf80386_desc_cache
  import rf80386_pkg::*;
#(
  parameter int NENT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DESC_TAG_W-1:0] lookup_tag,
  output logic                  lookup_hit,
  output desc386_t              lookup_data,
  input  logic                  fill_en,
  input  logic [DESC_TAG_W-1:0] fill_tag,
  input  desc386_t              fill_data,
  input  logic                  flush,
  input  logic                  flush_ldt
);
  localparam int PW = (NENT > 1) ? $clog2(NENT) : 1;

  logic [NENT-1:0]       valid;
  logic [DESC_TAG_W-1:0] tags [NENT];
  desc386_t              data [NENT];
  logic [PW-1:0]         victim;

  // A lookup racing an invalidate is treated as a miss.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    for (int i = 0; i < NENT; i++) begin
      if (valid[i] && (tags[i] == lookup_tag)) begin
        lookup_hit  = 1'b1;
        lookup_data = data[i];
      end
    end
    if (flush || (flush_ldt && lookup_tag[DESC_TAG_W-1]))
      lookup_hit = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid  <= '0;
      victim <= '0;
    end else begin
      if (fill_en) begin
        valid[victim] <= 1'b1;
        victim        <= (victim == PW'(NENT - 1)) ? '0 : victim + 1'b1;
      end
      if (flush) begin
        valid <= '0;
      end else if (flush_ldt) begin
        for (int i = 0; i < NENT; i++)
          if (tags[i][DESC_TAG_W-1]) valid[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (fill_en) begin
      tags[victim] <= fill_tag;
      data[victim] <= fill_data;
    end
  end

endmodule

// File: rtl/rf80386_desc_fetch.sv
// Descriptor fetch engine: selector range check against GDT/LDT, cache lookup,
// and multi-beat little-endian descriptor read over the master bus on a miss.
module rf80386_desc_fetch
  import rf80386_pkg::*;
#(
  parameter int DBW  = 32,
  parameter int NENT = 4,
  parameter int AW   = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  selector_t             sel_i,
  input  logic [AW-1:0]         gdt_base_i,
  input  logic [15:0]           gdt_limit_i,
  input  logic [AW-1:0]         ldt_base_i,
  input  logic [15:0]           ldt_limit_i,
  input  logic                  flush_i,
  input  logic                  flush_ldt_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  hit_o,
  output desc386_t              desc_o,
  output logic                  fault_o,
  output e_desc_fault           fault_code_o,
  rf80386_desc_fetch_if.master  bus
);
  localparam int BEATS = desc_beats(DBW);
  localparam int BYTES = DBW / 8;

  e_descfetch_state state;
  logic [12:0]      ndx_q;
  logic             ti_q;
  logic [AW-1:0]    base_q;
  logic [15:0]      limit_q;
  logic [2:0]       beat_q;
  logic [63:0]      asm_q;
  logic [63:0]      asm_next;
  logic             flush_pend;
  logic             flush_now;
  logic             null_sel;
  logic             over_limit;
  logic             c_hit;
  desc386_t         c_data;
  logic             fill_en;
  logic [AW-1:0]    fetch_adr;

  assign bus.we_o  = 1'b0;
  assign bus.sel_o = '1;

  assign null_sel   = (ndx_q == '0) && !ti_q;
  assign over_limit = {1'b0, ndx_q, 3'b111} > {1'b0, limit_q};
  assign fetch_adr  = base_q + AW'({ndx_q, 3'b000}) + AW'(beat_q) * AW'(BYTES);
  assign flush_now  = flush_i || (flush_ldt_i && ti_q);

  // A flush seen at any point of the transaction forbids caching its result.
  assign fill_en = (state == DF_DONE) && !hit_o && !fault_o && !flush_pend && !flush_now;

  always_comb begin
    asm_next = asm_q;
    asm_next[int'(beat_q) * DBW +: DBW] = bus.dat_i;
  end

  rf80386_desc_cache #(.NENT(NENT)) u_cache (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .lookup_tag  ({ti_q, ndx_q}),
    .lookup_hit  (c_hit),
    .lookup_data (c_data),
    .fill_en     (fill_en),
    .fill_tag    ({ti_q, ndx_q}),
    .fill_data   (desc_o),
    .flush       (flush_i),
    .flush_ldt   (flush_ldt_i)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= DF_IDLE;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      hit_o        <= 1'b0;
      fault_o      <= 1'b0;
      fault_code_o <= FLT_NONE;
      desc_o       <= '0;
      bus.cyc_o    <= 1'b0;
      bus.stb_o    <= 1'b0;
      bus.adr_o    <= '0;
      ndx_q        <= '0;
      ti_q         <= 1'b0;
      base_q       <= '0;
      limit_q      <= '0;
      beat_q       <= '0;
      asm_q        <= '0;
      flush_pend   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if ((state != DF_IDLE) && flush_now) flush_pend <= 1'b1;
      case (state)
        DF_IDLE: begin
          flush_pend <= 1'b0;
          if (req_i) begin
            ndx_q   <= sel_i.ndx;
            ti_q    <= sel_i.ti;
            base_q  <= sel_i.ti ? ldt_base_i  : gdt_base_i;
            limit_q <= sel_i.ti ? ldt_limit_i : gdt_limit_i;
            busy_o  <= 1'b1;
            state   <= DF_CHECK;
          end
        end
        DF_CHECK: begin
          beat_q       <= '0;
          hit_o        <= 1'b0;
          fault_o      <= 1'b0;
          fault_code_o <= FLT_NONE;
          if (null_sel) begin
            fault_o      <= 1'b1;
            fault_code_o <= FLT_NULLSEL;
            done_o       <= 1'b1;
            state        <= DF_DONE;
          end else if (over_limit) begin
            fault_o      <= 1'b1;
            fault_code_o <= FLT_LIMIT;
            done_o       <= 1'b1;
            state        <= DF_DONE;
          end else if (c_hit) begin
            hit_o  <= 1'b1;
            desc_o <= c_data;
            done_o <= 1'b1;
            state  <= DF_DONE;
          end else begin
            state <= DF_FETCH;
          end
        end
        DF_FETCH: begin
          bus.cyc_o <= 1'b1;
          bus.stb_o <= 1'b1;
          bus.adr_o <= fetch_adr;
          state     <= DF_FETCH_ACK;
        end
        DF_FETCH_ACK: begin
          if (bus.err_i) begin
            bus.cyc_o    <= 1'b0;
            bus.stb_o    <= 1'b0;
            fault_o      <= 1'b1;
            fault_code_o <= FLT_BUSERR;
            done_o       <= 1'b1;
            state        <= DF_DONE;
          end else if (bus.ack_i) begin
            bus.stb_o <= 1'b0;
            asm_q     <= asm_next;
            if (beat_q == 3'(BEATS - 1)) begin
              bus.cyc_o <= 1'b0;
              desc_o    <= asm_next;
              done_o    <= 1'b1;
              state     <= DF_DONE;
            end else begin
              beat_q <= beat_q + 3'd1;
              state  <= DF_FETCH;
            end
          end
        end
        DF_DONE: begin
          busy_o <= 1'b0;
          state  <= DF_IDLE;
        end
        default: state <= DF_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rf80386_desc_fetch.sv
// Directed bench for rf80386_desc_fetch with a 16-bit data bus and a 4-entry cache.
`timescale 1ns/1ps
module tb_rf80386_desc_fetch;
  import rf80386_pkg::*;

  localparam int DBW  = 16;
  localparam int NENT = 4;
  localparam int AW   = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [15:0] sel = '0;
  logic [31:0] gdt_base = 32'h0000_1000;
  logic [15:0] gdt_limit = 16'h001F;
  logic [31:0] ldt_base = 32'h0000_2000;
  logic [15:0] ldt_limit = 16'h003F;
  logic        flush = 1'b0;
  logic        flush_ldt = 1'b0;
  logic        busy, done, hit, fault;
  desc386_t    desc;
  e_desc_fault fcode;

  always #5 clk = ~clk;

  rf80386_desc_fetch_if #(.DBW(DBW), .AW(AW)) bus ();

  rf80386_desc_fetch #(.DBW(DBW), .NENT(NENT), .AW(AW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_i        (req),
    .sel_i        (sel),
    .gdt_base_i   (gdt_base),
    .gdt_limit_i  (gdt_limit),
    .ldt_base_i   (ldt_base),
    .ldt_limit_i  (ldt_limit),
    .flush_i      (flush),
    .flush_ldt_i  (flush_ldt),
    .busy_o       (busy),
    .done_o       (done),
    .hit_o        (hit),
    .desc_o       (desc),
    .fault_o      (fault),
    .fault_code_o (fcode),
    .bus          (bus)
  );

  typedef struct {
    logic [15:0] sel;
    int          act;      // 0 plain, 1 flush_ldt before, 2 bus error on beat 1, 3 flush mid-fetch
    logic        fault;
    logic [1:0]  code;
    logic        hit;
    logic        use_bus;
    logic [31:0] adr0;
    logic        chk_desc;
    logic [63:0] desc;
  } vec_t;

  vec_t        vecs[$];
  int          n_chk = 0;
  int          n_fail = 0;

  logic        r_done, r_hit, r_fault, r_err_chk, r_err_cyc;
  logic [1:0]  r_code;
  logic [63:0] r_desc;
  int          r_lat, r_cyc;
  logic [31:0] adr_q[$];

  function automatic logic [15:0] mem16(input logic [31:0] a);
    return a[15:0] ^ 16'hC3A5;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [15:0] s, input int act, input logic f, input logic [1:0] c,
                     input logic h, input logic b, input logic [31:0] a0,
                     input logic cd, input logic [63:0] d);
    vec_t v;
    v.sel = s; v.act = act; v.fault = f; v.code = c; v.hit = h;
    v.use_bus = b; v.adr0 = a0; v.chk_desc = cd; v.desc = d;
    vecs.push_back(v);
  endtask

  // Issues one request and plays the bus slave (zero-wait ack) until done_o or the budget runs out.
  task automatic do_req(input logic [15:0] s, input int err_at, input int flush_at);
    int   beat;
    logic err_prev;
    beat = 0; err_prev = 1'b0;
    r_done = 1'b0; r_lat = 0; r_cyc = 0; r_err_chk = 1'b0; r_err_cyc = 1'b0;
    r_hit = 1'b0; r_fault = 1'b0; r_code = '0; r_desc = '0;
    adr_q.delete();
    @(negedge clk);
    sel = s;
    req = 1'b1;
    for (int lat = 1; lat <= 200 && !r_done; lat++) begin
      @(negedge clk);
      req = 1'b0;
      flush = (lat == flush_at);
      if (err_prev) begin
        r_err_chk = 1'b1;
        r_err_cyc = bus.cyc_o;
      end
      err_prev = 1'b0;
      bus.ack_i = 1'b0;
      bus.err_i = 1'b0;
      if (bus.cyc_o) r_cyc++;
      if (bus.stb_o) begin
        if (beat == err_at) begin
          bus.err_i = 1'b1;
          err_prev  = 1'b1;
        end else begin
          bus.ack_i = 1'b1;
          bus.dat_i = mem16(bus.adr_o);
          adr_q.push_back(bus.adr_o);
        end
        beat++;
      end
      if (done) begin
        r_done = 1'b1; r_lat = lat; r_hit = hit; r_fault = fault;
        r_code = fcode; r_desc = desc;
      end
    end
    bus.ack_i = 1'b0;
    bus.err_i = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ack_i = 1'b0;
    bus.err_i = 1'b0;
    bus.dat_i = '0;

    //          sel      act f  code  h  bus adr0          cd desc
    add(16'h0000, 0, 1, 2'd1, 0, 0, 32'h0,         0, 64'h0);
    add(16'h0003, 0, 1, 2'd1, 0, 0, 32'h0,         0, 64'h0);
    add(16'h0020, 0, 1, 2'd2, 0, 0, 32'h0,         0, 64'h0);
    add(16'h0044, 0, 1, 2'd2, 0, 0, 32'h0,         0, 64'h0);
    add(16'h0018, 0, 0, 2'd0, 0, 1, 32'h0000_1018, 1, 64'hD3BB_D3B9_D3BF_D3BD);
    add(16'h0018, 0, 0, 2'd0, 1, 0, 32'h0,         1, 64'hD3BB_D3B9_D3BF_D3BD);
    add(16'h0010, 0, 0, 2'd0, 0, 1, 32'h0000_1010, 1, 64'hD3B3_D3B1_D3B7_D3B5);
    add(16'h0010, 0, 0, 2'd0, 1, 0, 32'h0,         1, 64'hD3B3_D3B1_D3B7_D3B5);
    add(16'h0004, 0, 0, 2'd0, 0, 1, 32'h0000_2000, 1, 64'hE3A3_E3A1_E3A7_E3A5);
    add(16'h0004, 0, 0, 2'd0, 1, 0, 32'h0,         1, 64'hE3A3_E3A1_E3A7_E3A5);
    add(16'h000C, 2, 1, 2'd3, 0, 1, 32'h0000_2008, 0, 64'h0);
    add(16'h000C, 0, 0, 2'd0, 0, 1, 32'h0000_2008, 1, 64'hE3AB_E3A9_E3AF_E3AD);
    add(16'h000C, 0, 0, 2'd0, 1, 0, 32'h0,         1, 64'hE3AB_E3A9_E3AF_E3AD);
    add(16'h0014, 0, 0, 2'd0, 0, 1, 32'h0000_2010, 1, 64'hE3B3_E3B1_E3B7_E3B5);
    add(16'h0010, 0, 0, 2'd0, 1, 0, 32'h0,         1, 64'hD3B3_D3B1_D3B7_D3B5);
    add(16'h0018, 0, 0, 2'd0, 0, 1, 32'h0000_1018, 1, 64'hD3BB_D3B9_D3BF_D3BD);
    add(16'h0018, 1, 0, 2'd0, 1, 0, 32'h0,         1, 64'hD3BB_D3B9_D3BF_D3BD);
    add(16'h0004, 0, 0, 2'd0, 0, 1, 32'h0000_2000, 1, 64'hE3A3_E3A1_E3A7_E3A5);
    add(16'h000C, 0, 0, 2'd0, 0, 1, 32'h0000_2008, 1, 64'hE3AB_E3A9_E3AF_E3AD);
    add(16'h0010, 3, 0, 2'd0, 0, 1, 32'h0000_1010, 1, 64'hD3B3_D3B1_D3B7_D3B5);
    add(16'h0010, 0, 0, 2'd0, 0, 1, 32'h0000_1010, 1, 64'hD3B3_D3B1_D3B7_D3B5);
    add(16'h0018, 0, 0, 2'd0, 0, 1, 32'h0000_1018, 1, 64'hD3BB_D3B9_D3BF_D3BD);

    #12;
    chk("rst.busy",  busy,      1'b0);
    chk("rst.done",  done,      1'b0);
    chk("rst.hit",   hit,       1'b0);
    chk("rst.fault", fault,     1'b0);
    chk("rst.code",  fcode,     2'd0);
    chk("rst.desc",  desc,      64'h0);
    chk("rst.cyc",   bus.cyc_o, 1'b0);
    chk("rst.stb",   bus.stb_o, 1'b0);
    chk("rst.adr",   bus.adr_o, 32'h0);
    chk("rst.we",    bus.we_o,  1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      if (v.act == 1) begin
        @(negedge clk); flush_ldt = 1'b1;
        @(negedge clk); flush_ldt = 1'b0;
      end
      do_req(v.sel, (v.act == 2) ? 1 : -1, (v.act == 3) ? 4 : 0);
      chk($sformatf("v%0d.done", i), r_done, 1'b1);
      if (r_done) begin
        chk($sformatf("v%0d.fault", i), r_fault, v.fault);
        chk($sformatf("v%0d.code", i), r_code, v.code);
        chk($sformatf("v%0d.hit", i), r_hit, v.hit);
        chk($sformatf("v%0d.bus", i), (r_cyc != 0), v.use_bus);
        if (!v.use_bus) chk($sformatf("v%0d.latency", i), r_lat, 2);
        if (v.chk_desc) chk($sformatf("v%0d.desc", i), r_desc, v.desc);
        if (v.use_bus && !v.fault) begin
          chk($sformatf("v%0d.beats", i), adr_q.size(), 4);
          for (int k = 0; k < adr_q.size() && k < 4; k++)
            chk($sformatf("v%0d.adr%0d", i, k), adr_q[k], v.adr0 + 32'(2 * k));
        end
        if (v.act == 2) begin
          chk($sformatf("v%0d.err_seen", i), r_err_chk, 1'b1);
          chk($sformatf("v%0d.cyc_after_err", i), r_err_cyc, 1'b0);
        end
      end
    end

    // Reset while a beat is stalled in FETCH_ACK (slave withholds ack).
    @(negedge clk);
    sel = 16'h0004;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    for (int k = 0; k < 20 && !bus.stb_o; k++) @(negedge clk);
    chk("rstmid.stb_before", bus.stb_o, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid.cyc", bus.cyc_o, 1'b0);
    chk("rstmid.stb", bus.stb_o, 1'b0);
    chk("rstmid.busy", busy, 1'b0);
    chk("rstmid.done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid.busy_after", busy, 1'b0);

    do_req(16'h0010, -1, 0);
    chk("post_rst.0010.done", r_done, 1'b1);
    chk("post_rst.0010.hit", r_hit, 1'b0);
    chk("post_rst.0010.bus", (r_cyc != 0), 1'b1);
    chk("post_rst.0010.desc", r_desc, 64'hD3B3_D3B1_D3B7_D3B5);
    do_req(16'h0018, -1, 0);
    chk("post_rst.0018.done", r_done, 1'b1);
    chk("post_rst.0018.hit", r_hit, 1'b0);
    chk("post_rst.0018.bus", (r_cyc != 0), 1'b1);
    do_req(16'h0010, -1, 0);
    chk("post_rst.0010_again.hit", r_hit, 1'b1);
    chk("post_rst.0010_again.latency", r_lat, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
